// File: rtl/div_pkg.sv
// Shared definitions for the clock_divider family and its tick consumers.
package div_pkg;
  localparam int COUNT_WIDTH_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_e;
endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for clk-synchronous level signals such as divider outputs.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic step
);
  logic sig_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_prev <= 1'b0;
    else     sig_prev <= sig;
  end

  assign step = sig & ~sig_prev;
endmodule

// File: rtl/pwm_tick_gen.sv
// PWM generator stepped by rising edges of a divider output, with shadowed duty/period.
module pwm_tick_gen
  import div_pkg::*;
#(
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick_in,
  input  logic                   enable,
  input  logic [COUNT_WIDTH-1:0] period_max,
  input  logic [COUNT_WIDTH-1:0] duty,
  output logic                   pwm_out,
  output logic                   cycle_done,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   busy
);
  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  pwm_state_e             state, state_nxt;
  logic                   step, wrap;
  logic [COUNT_WIDTH-1:0] duty_sh, period_sh;

  rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .sig  (tick_in),
    .step (step)
  );

  // Compare precedes increment, so a full-range period never overflows.
  assign wrap = (state == RUN) && step && (count == period_sh);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (wrap && !enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      duty_sh    <= '0;
      period_sh  <= '0;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      if (state == IDLE) begin
        count <= '0;
        if (enable) begin
          duty_sh   <= duty;
          period_sh <= period_max;
        end
      end else if (wrap) begin
        count      <= '0;
        cycle_done <= 1'b1;
        duty_sh    <= duty;
        period_sh  <= period_max;
      end else if (step) begin
        count <= count + ONE;
      end
    end
  end

  assign busy    = (state == RUN);
  assign pwm_out = (state == RUN) && (count < duty_sh);
endmodule

// File: tb/tb_pwm_tick_gen.sv
// Directed bench with a per-cycle expected-output queue and period statistics.
module tb_pwm_tick_gen;
  localparam int CW = 4;

  typedef struct packed {
    logic          pwm;
    logic          cd;
    logic          busy;
    logic [CW-1:0] cnt;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick_in = 1'b0;
  logic          enable = 1'b0;
  logic [CW-1:0] period_max = 4'd3;
  logic [CW-1:0] duty = 4'd2;
  logic          pwm_out, cycle_done, busy;
  logic [CW-1:0] count;

  pwm_tick_gen #(.COUNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_in    (tick_in),
    .enable     (enable),
    .period_max (period_max),
    .duty       (duty),
    .pwm_out    (pwm_out),
    .cycle_done (cycle_done),
    .count      (count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  obs_t sbq[$];
  int   dcnt = 0;

  // reference state
  logic          m_run = 1'b0;
  logic          m_prev = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  logic [CW-1:0] m_dsh = '0;
  logic [CW-1:0] m_psh = '0;

  // per-period statistics measured on the DUT outputs
  int            since = 0;
  int            hi = 0;
  int            last_len = 0;
  int            last_hi = 0;
  logic [CW-1:0] pre_cnt = '0;
  logic [CW-1:0] last_pre = '0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_prev = 1'b0;
    m_cnt  = '0;
    m_dsh  = '0;
    m_psh  = '0;
    since  = 0;
    hi     = 0;
  endtask

  // One clk: advance the divider (6 clk high / 6 low), predict, clock, compare.
  task automatic cyc();
    logic stp, n_cd;
    obs_t e, o;
    if (dcnt == 5) begin
      dcnt    = 0;
      tick_in = ~tick_in;
    end else begin
      dcnt++;
    end
    stp    = tick_in & ~m_prev;
    m_prev = tick_in;
    n_cd   = 1'b0;
    if (!m_run) begin
      m_cnt = '0;
      if (enable) begin
        m_run = 1'b1;
        m_dsh = duty;
        m_psh = period_max;
      end
    end else if (stp) begin
      if (m_cnt == m_psh) begin
        m_cnt = '0;
        n_cd  = 1'b1;
        m_dsh = duty;
        m_psh = period_max;
        if (!enable) m_run = 1'b0;
      end else begin
        m_cnt = m_cnt + CW'(1);
      end
    end
    e.pwm  = m_run && (m_cnt < m_dsh);
    e.cd   = n_cd;
    e.busy = m_run;
    e.cnt  = m_cnt;
    sbq.push_back(e);

    @(posedge clk);
    #2;
    o = {pwm_out, cycle_done, busy, count};
    e = sbq.pop_front();
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL sb t=%0t observed=%h expected=%h", $time, o, e);
    end

    if (cycle_done === 1'b1) begin
      last_len = since;
      last_hi  = hi;
      last_pre = pre_cnt;
      since    = 0;
      hi       = 0;
    end
    since++;
    if (pwm_out === 1'b1) hi++;
    pre_cnt = count;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic wait_cnt(input int v, input string tag);
    int n = 0;
    while (count !== CW'(v) && n < 200) begin
      cyc();
      n++;
    end
    chk(tag, int'(count), v);
  endtask

  task automatic wait_cd(input string tag);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (cycle_done !== 1'b1 && n < 400);
    chk(tag, int'(cycle_done), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_pwm",  int'(pwm_out), 0);
    chk("rst_cd",   int'(cycle_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt",  int'(count), 0);
    rst = 1'b0;
    model_reset();
    run(5);
    chk("idle_busy", int'(busy), 0);

    // basic: period_max=3, duty=2
    enable = 1'b1;
    run(100);
    wait_cd("basic_cd");
    chk("basic_len", last_len, 48);
    chk("basic_hi",  last_hi, 24);
    chk("basic_top", int'(last_pre), 3);

    // duty extremes
    duty = 4'd0;
    wait_cd("d0_load");
    wait_cd("d0_cd");
    chk("d0_hi",  last_hi, 0);
    chk("d0_len", last_len, 48);
    duty = 4'd5;
    wait_cd("d5_load");
    wait_cd("d5_cd");
    chk("d5_hi",  last_hi, 48);
    chk("d5_len", last_len, 48);

    // shadow reload: duty 2 -> 1 mid-period
    duty = 4'd2;
    wait_cd("sh_load");
    wait_cd("sh_steady");
    wait_cnt(1, "sh_at1");
    duty = 4'd1;
    wait_cd("sh_cd1");
    chk("sh_hi_old", last_hi, 24);
    wait_cd("sh_cd2");
    chk("sh_hi_new", last_hi, 12);

    // graceful stop
    wait_cnt(1, "stop_at1");
    enable = 1'b0;
    wait_cd("stop_cd");
    chk("stop_busy", int'(busy), 0);
    chk("stop_cnt",  int'(count), 0);
    chk("stop_top",  int'(last_pre), 3);
    run(40);
    chk("stop_hold_busy", int'(busy), 0);
    chk("stop_hold_pwm",  int'(pwm_out), 0);
    chk("stop_hold_cnt",  int'(count), 0);

    // reset mid-operation
    duty   = 4'd3;
    enable = 1'b1;
    wait_cnt(2, "rm_at2");
    chk("rm_pre_pwm", int'(pwm_out), 1);
    #1 rst = 1'b1;
    #1;
    chk("rm_pwm",  int'(pwm_out), 0);
    chk("rm_cnt",  int'(count), 0);
    chk("rm_busy", int'(busy), 0);
    chk("rm_cd",   int'(cycle_done), 0);
    rst = 1'b0;
    model_reset();
    cyc();
    chk("rm_reenter", int'(busy), 1);
    run(60);

    // period_max=0: wrap on every step
    duty       = 4'd1;
    period_max = 4'd0;
    wait_cd("p0_load");
    wait_cd("p0_cd");
    chk("p0_len", last_len, 12);
    chk("p0_hi",  last_hi, 12);
    chk("p0_top", int'(last_pre), 0);

    // full-range period
    period_max = 4'd15;
    duty       = 4'd8;
    wait_cd("pf_load");
    wait_cd("pf_cd");
    chk("pf_len", last_len, 192);
    chk("pf_hi",  last_hi, 96);
    chk("pf_top", int'(last_pre), 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
